// File: rtl/y86_pkg.sv
// y86_pkg: Y86 instruction codes, register IDs, status codes and bubble constants.
package y86_pkg;
   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] CMOVXX = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [3:0] RNONE  = 4'hF;
   localparam logic [3:0] RSP    = 4'h4;

   localparam logic [3:0] AOK    = 4'h8;
   localparam logic [3:0] HLT    = 4'h4;
   localparam logic [3:0] ADR    = 4'h2;
   localparam logic [3:0] INS    = 4'h1;

   localparam logic [3:0] BUBBLE_ICODE = NOP;
   localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
   localparam logic [3:0] BUBBLE_STAT  = AOK;
endpackage

// File: rtl/decode_writeback_if.sv
// decode_writeback_if: D/E pipeline registers, forwarding sources and writeback ports.
interface decode_writeback_if #(parameter int WIDTH = 64);
   logic [3:0]       D_icode, D_ifun, D_rA, D_rB, D_stat;
   logic [WIDTH-1:0] D_valC, D_valP;
   logic             E_bubble;
   logic [3:0]       e_dstE;
   logic [WIDTH-1:0] e_valE;
   logic [3:0]       M_dstE, M_dstM;
   logic [WIDTH-1:0] M_valE, m_valM;
   logic [3:0]       W_dstE, W_dstM;
   logic [WIDTH-1:0] W_valE, W_valM;
   logic [3:0]       d_srcA, d_srcB;
   logic [3:0]       E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_stat;
   logic [WIDTH-1:0] E_valC, E_valA, E_valB;

   modport master (
      output D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP, E_bubble,
             e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
             W_dstE, W_dstM, W_valE, W_valM,
      input  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
             E_stat, E_valC, E_valA, E_valB
   );

   modport slave (
      input  D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP, E_bubble,
             e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
             W_dstE, W_dstM, W_valE, W_valM,
      output d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
             E_stat, E_valC, E_valA, E_valB
   );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: 15-entry register file, 2 comb reads (ID F reads 0), 2 writes (M port wins).
// Without DECODE_FWD_EN the read ports see same-edge writes (write-through).
module y86_regfile
   import y86_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       ra_id,
   input  logic [3:0]       rb_id,
   output logic [WIDTH-1:0] ra_val,
   output logic [WIDTH-1:0] rb_val,
   input  logic [3:0]       we_id,
   input  logic [WIDTH-1:0] we_val,
   input  logic [3:0]       wm_id,
   input  logic [WIDTH-1:0] wm_val
);
   logic [WIDTH-1:0] regs [15];

`ifdef DECODE_FWD_EN
   assign ra_val = (ra_id == RNONE) ? '0 : regs[ra_id];
   assign rb_val = (rb_id == RNONE) ? '0 : regs[rb_id];
`else
   assign ra_val = (ra_id == RNONE) ? '0 : (ra_id == wm_id) ? wm_val :
                   (ra_id == we_id) ? we_val : regs[ra_id];
   assign rb_val = (rb_id == RNONE) ? '0 : (rb_id == wm_id) ? wm_val :
                   (rb_id == we_id) ? we_val : regs[rb_id];
`endif

   always_ff @(posedge clk)
      for (int i = 0; i < 15; i++)
         if (rst) regs[i] <= '0;
         else if (wm_id == 4'(i)) regs[i] <= wm_val;
         else if (we_id == 4'(i)) regs[i] <= we_val;
endmodule

// File: rtl/decode_writeback.sv
// decode_writeback: Y86 decode + writeback stage, loads the E pipeline register.
// DECODE_FWD_EN enables e/M/W operand forwarding; otherwise only regfile write-through.
module decode_writeback
   import y86_pkg::*;
#(
   parameter int         WIDTH  = 64,
   parameter logic [3:0] RSP_ID = RSP
) (
   input logic          clk,
   input logic          rst,
   decode_writeback_if.slave bus
);
   logic [3:0]       icode, src_a, src_b, dst_e, dst_m;
   logic [WIDTH-1:0] rf_a, rf_b, fwd_a, fwd_b, val_a;

   assign icode = bus.D_icode;

   always_comb begin
      src_a = (icode inside {CMOVXX, RMMOVQ, OPQ, PUSHQ}) ? bus.D_rA :
              (icode inside {POPQ, RET}) ? RSP_ID : RNONE;
      src_b = (icode inside {RMMOVQ, MRMOVQ, OPQ}) ? bus.D_rB :
              (icode inside {PUSHQ, POPQ, CALL, RET}) ? RSP_ID : RNONE;
      dst_e = (icode inside {CMOVXX, IRMOVQ, OPQ}) ? bus.D_rB :
              (icode inside {PUSHQ, POPQ, CALL, RET}) ? RSP_ID : RNONE;
      dst_m = (icode inside {MRMOVQ, POPQ}) ? bus.D_rA : RNONE;
   end

   assign bus.d_srcA = src_a;
   assign bus.d_srcB = src_b;

   y86_regfile #(.WIDTH(WIDTH)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .ra_id  (src_a),
      .rb_id  (src_b),
      .ra_val (rf_a),
      .rb_val (rf_b),
      .we_id  (bus.W_dstE),
      .we_val (bus.W_valE),
      .wm_id  (bus.W_dstM),
      .wm_val (bus.W_valM)
   );

`ifdef DECODE_FWD_EN
   always_comb begin
      fwd_a = (src_a == RNONE) ? rf_a :
              (src_a == bus.e_dstE) ? bus.e_valE :
              (src_a == bus.M_dstM) ? bus.m_valM :
              (src_a == bus.M_dstE) ? bus.M_valE :
              (src_a == bus.W_dstM) ? bus.W_valM :
              (src_a == bus.W_dstE) ? bus.W_valE : rf_a;
      fwd_b = (src_b == RNONE) ? rf_b :
              (src_b == bus.e_dstE) ? bus.e_valE :
              (src_b == bus.M_dstM) ? bus.m_valM :
              (src_b == bus.M_dstE) ? bus.M_valE :
              (src_b == bus.W_dstM) ? bus.W_valM :
              (src_b == bus.W_dstE) ? bus.W_valE : rf_b;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{bus.e_dstE, bus.e_valE, bus.M_dstE, bus.M_dstM, bus.M_valE, bus.m_valM};
   assign fwd_a = rf_a;
   assign fwd_b = rf_b;
`endif

   // call/jxx carry the return/fall-through PC in valA
   assign val_a = (icode == CALL || icode == JXX) ? bus.D_valP : fwd_a;

   always_ff @(posedge clk) begin
      if (rst || bus.E_bubble) begin
         bus.E_icode <= BUBBLE_ICODE;
         bus.E_ifun  <= BUBBLE_IFUN;
         bus.E_valC  <= '0;
         bus.E_valA  <= '0;
         bus.E_valB  <= '0;
         bus.E_dstE  <= RNONE;
         bus.E_dstM  <= RNONE;
         bus.E_srcA  <= RNONE;
         bus.E_srcB  <= RNONE;
         bus.E_stat  <= BUBBLE_STAT;
      end else begin
         bus.E_icode <= bus.D_icode;
         bus.E_ifun  <= bus.D_ifun;
         bus.E_valC  <= bus.D_valC;
         bus.E_valA  <= val_a;
         bus.E_valB  <= fwd_b;
         bus.E_dstE  <= dst_e;
         bus.E_dstM  <= dst_m;
         bus.E_srcA  <= src_a;
         bus.E_srcB  <= src_b;
         bus.E_stat  <= bus.D_stat;
      end
   end
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed vectors with hand-computed expectations for decode_writeback.
module tb_decode_writeback;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   decode_writeback_if #(.WIDTH(64)) bus ();

   decode_writeback #(.WIDTH(64), .RSP_ID(4'h4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                          input logic [3:0] st);
      bus.D_icode = ic;
      bus.D_ifun  = fn;
      bus.D_rA    = ra;
      bus.D_rB    = rb;
      bus.D_valC  = vc;
      bus.D_valP  = vp;
      bus.D_stat  = st;
   endtask

   task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm,
                     input logic [63:0] vm);
      bus.W_dstE = de;
      bus.W_valE = ve;
      bus.W_dstM = dm;
      bus.W_valM = vm;
   endtask

   task automatic fwd(input logic [3:0] ed, input logic [63:0] ev, input logic [3:0] mdm,
                      input logic [63:0] mvm);
      bus.e_dstE = ed;
      bus.e_valE = ev;
      bus.M_dstM = mdm;
      bus.m_valM = mvm;
      bus.M_dstE = 4'hF;
      bus.M_valE = 64'h0;
   endtask

   initial begin
      rst = 1'b1;
      bus.E_bubble = 1'b0;
      fwd(4'hF, 0, 4'hF, 0);
      wb(4'h2, 64'h55, 4'hF, 0);
      drive_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 64'h0, 4'h8);
      step();
      rst = 1'b0;
      wb(4'hF, 0, 4'hF, 0);
      check("rst_icode", bus.E_icode, 64'h1);
      check("rst_dstE", bus.E_dstE, 64'hF);
      check("rst_stat", bus.E_stat, 64'h8);
      check("rst_valC", bus.E_valC, 64'h0);
      check("rst_srcA", bus.E_srcA, 64'hF);

      drive_d(4'h2, 4'h0, 4'h2, 4'h7, 0, 0, 4'h8);
      step();
      check("rd_reg2_zero", bus.E_valA, 64'h0);
      check("rr_srcA", bus.E_srcA, 64'h2);
      check("rr_dstE", bus.E_dstE, 64'h7);
      check("rr_icode", bus.E_icode, 64'h2);
      check("rr_stat", bus.E_stat, 64'h8);

      drive_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 0, 4'h8);
      #1;
      check("irm_d_srcA", bus.d_srcA, 64'hF);
      check("irm_d_srcB", bus.d_srcB, 64'hF);
      step();
      check("irm_dstE", bus.E_dstE, 64'h2);
      check("irm_valC", bus.E_valC, 64'h10);
      check("irm_srcA", bus.E_srcA, 64'hF);
      check("irm_dstM", bus.E_dstM, 64'hF);

      wb(4'h2, 64'h10, 4'hF, 0);
      drive_d(4'h2, 4'h0, 4'h2, 4'h3, 0, 0, 4'h8);
      step();
      check("wb_same_edge", bus.E_valA, 64'h10);
      wb(4'hF, 0, 4'hF, 0);
      step();
      check("wb_stored", bus.E_valA, 64'h10);

`ifdef DECODE_FWD_EN
      fwd(4'h3, 64'hAA, 4'h3, 64'hBB);
      drive_d(4'h6, 4'h1, 4'h3, 4'h2, 0, 0, 4'h8);
      step();
      check("fwd_e_prio", bus.E_valA, 64'hAA);
      check("fwd_valB_rf", bus.E_valB, 64'h10);
      fwd(4'hF, 0, 4'h3, 64'hBB);
      step();
      check("fwd_m_valM", bus.E_valA, 64'hBB);
`else
      fwd(4'h3, 64'hAA, 4'h3, 64'hBB);
      drive_d(4'h6, 4'h1, 4'h3, 4'h2, 0, 0, 4'h8);
      step();
      check("nofwd_ignored", bus.E_valA, 64'h0);
`endif
      fwd(4'hF, 0, 4'hF, 0);

      wb(4'h3, 64'h7, 4'hF, 0);
      drive_d(4'h6, 4'h1, 4'h3, 4'h2, 0, 0, 4'h8);
      step();
      check("op_wt_valA", bus.E_valA, 64'h7);
      check("op_valB", bus.E_valB, 64'h10);
      check("op_ifun", bus.E_ifun, 64'h1);
      check("op_dstE", bus.E_dstE, 64'h2);
      check("op_srcB", bus.E_srcB, 64'h2);

      wb(4'h5, 64'h1, 4'h5, 64'h2);
      drive_d(4'h2, 4'h0, 4'h5, 4'h1, 0, 0, 4'h8);
      step();
      check("wt_m_prio", bus.E_valA, 64'h2);
      wb(4'hF, 0, 4'hF, 0);

      drive_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40, 4'h8);
      step();
      check("call_valA", bus.E_valA, 64'h40);
      check("call_srcB", bus.E_srcB, 64'h4);
      check("call_dstE", bus.E_dstE, 64'h4);
      check("call_srcA", bus.E_srcA, 64'hF);
      check("call_valC", bus.E_valC, 64'h100);

      drive_d(4'hB, 4'h0, 4'h5, 4'hF, 0, 0, 4'h8);
      step();
      check("pop_srcA", bus.E_srcA, 64'h4);
      check("pop_srcB", bus.E_srcB, 64'h4);
      check("pop_dstE", bus.E_dstE, 64'h4);
      check("pop_dstM", bus.E_dstM, 64'h5);

      wb(4'h6, 64'h1, 4'h6, 64'h2);
      bus.E_bubble = 1'b1;
      drive_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h99, 0, 4'h8);
      step();
      check("bub_icode", bus.E_icode, 64'h1);
      check("bub_dstE", bus.E_dstE, 64'hF);
      check("bub_valC", bus.E_valC, 64'h0);
      check("bub_stat", bus.E_stat, 64'h8);
      bus.E_bubble = 1'b0;
      wb(4'hF, 0, 4'hF, 0);

      drive_d(4'hA, 4'h0, 4'h6, 4'hF, 0, 0, 4'h8);
      #1;
      check("push_d_srcA", bus.d_srcA, 64'h6);
      check("push_d_srcB", bus.d_srcB, 64'h4);
      step();
      check("dual_wr_reg6", bus.E_valA, 64'h2);
      check("push_dstE", bus.E_dstE, 64'h4);

      drive_d(4'h5, 4'h0, 4'h7, 4'h6, 64'h8, 0, 4'h8);
      step();
      check("mrm_srcA", bus.E_srcA, 64'hF);
      check("mrm_srcB", bus.E_srcB, 64'h6);
      check("mrm_dstM", bus.E_dstM, 64'h7);
      check("mrm_dstE", bus.E_dstE, 64'hF);
      check("mrm_valB", bus.E_valB, 64'h2);

      drive_d(4'h4, 4'h0, 4'h2, 4'h6, 0, 0, 4'h8);
      step();
      check("rmm_valA", bus.E_valA, 64'h10);
      check("rmm_valB", bus.E_valB, 64'h2);
      check("rmm_dstE", bus.E_dstE, 64'hF);

      drive_d(4'hC, 4'h3, 4'h2, 4'h3, 64'h123, 0, 4'h1);
      step();
      check("inv_icode", bus.E_icode, 64'hC);
      check("inv_srcA", bus.E_srcA, 64'hF);
      check("inv_srcB", bus.E_srcB, 64'hF);
      check("inv_dstE", bus.E_dstE, 64'hF);
      check("inv_dstM", bus.E_dstM, 64'hF);
      check("inv_stat", bus.E_stat, 64'h1);
      check("inv_valC", bus.E_valC, 64'h123);
      check("inv_valA", bus.E_valA, 64'h0);

      drive_d(4'h7, 4'h2, 4'hF, 4'hF, 64'h200, 64'h77, 4'h8);
      step();
      check("jxx_valA", bus.E_valA, 64'h77);
      check("jxx_srcA", bus.E_srcA, 64'hF);

      drive_d(4'h9, 4'h0, 4'hF, 4'hF, 0, 0, 4'h8);
      step();
      check("ret_srcA", bus.E_srcA, 64'h4);
      check("ret_dstE", bus.E_dstE, 64'h4);
      check("ret_dstM", bus.E_dstM, 64'hF);

      drive_d(4'h0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h4);
      step();
      check("halt_stat", bus.E_stat, 64'h4);
      check("halt_dstE", bus.E_dstE, 64'hF);

      rst = 1'b1;
      step();
      rst = 1'b0;
      drive_d(4'h2, 4'h0, 4'h3, 4'h1, 0, 0, 4'h8);
      step();
      check("rst_clears_reg3", bus.E_valA, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
